pipe_sum_accum: RTL
===================

Name: pipe_sum_accum

Overview:
- Downstream consumer of the two-stage pipelined split adder.
- Takes the adder's registered {cout, sum} result stream, qualified by a valid/ready handshake.
- Accumulates COUNT consecutive results into a wider accumulator, then presents the total on a held output handshake.
- Provides block-sum (dot-product style) reduction after the adder pipeline.

Parameters:
- N, 5, width of the adder sum input.
- ACC_W, 8, accumulator and result width; must satisfy ACC_W >= N+1.
- COUNT, 4, number of accepted results per block; must satisfy COUNT >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_sum/in_cout hold a valid adder result.
- in_sum  input  N  adder sum.
- in_cout  input  1  adder carry-out.
- in_ready  output  1  block can accept an input this cycle.
- out_valid  output  1  out_acc/out_ovf hold a completed block result.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated block total.
- out_ovf  output  1  sticky overflow flag for the current block.

Behaviour:
- Operand value: v = {in_cout, in_sum}, (N+1) bits, zero-extended to ACC_W+1 bits for the addition.
- Input accept: in_valid && in_ready at a rising edge. Output accept: out_valid && out_ready at a rising edge.
- States: IDLE, ACCUM, DONE (registered, binary-encoded).
- Reset, asynchronous: state=IDLE, acc=0, cnt=0, ovf=0. Outputs during reset: out_valid=0, out_acc=0, out_ovf=0, in_ready=1.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE. out_valid = 1 only in DONE.
- IDLE, on input accept:
  - acc<=v, cnt<=1, ovf<=0.
  - Next state is DONE if COUNT==1, otherwise ACCUM.
- ACCUM, on input accept:
  - acc<=(acc+v) mod 2^ACC_W; ovf<=ovf | carry out of bit ACC_W-1; cnt<=cnt+1.
  - When cnt==COUNT-1 before the update, next state is DONE.
- ACCUM without input accept: all state holds; gaps of any length are allowed.
- DONE:
  - out_acc=acc and out_ovf=ovf, both stable while out_valid=1 && out_ready=0.
  - On output accept: state<=IDLE, cnt<=0. acc and ovf are cleared on the next IDLE accept.
  - out_acc is driven from acc in all states; it is only meaningful while out_valid=1.
- Latency: out_valid rises on the cycle after the COUNT-th input accept.
- Throughput: one bubble cycle per block (DONE→IDLE).
- Simultaneous in_valid and out_ready in DONE: the input is not accepted (in_ready=0). It is accepted in IDLE on the following cycle if in_valid is still high.
- in_ready depends only on registered state, with no combinational path from out_ready.
- cnt width: $clog2(COUNT+1); cnt never exceeds COUNT.
- Reset mid-block: any partial accumulation is discarded; no output is produced for that block.
- Inputs are ignored whenever in_valid=0, whatever in_sum/in_cout carry (X-tolerant).

Optional Feature:
- Macro: PIPE_SUM_ACCUM_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the block; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf=1.
- All other timing is identical in both builds.

Decomposition:
- Package pipe_accum_pkg:
  - typedef enum accum_state_t {IDLE, ACCUM, DONE};
  - localparam helper for cnt width.
- Sub-module accum_add: combinational ACC_W add of acc and v. Outputs the next acc and an overflow bit; the saturation option is handled inside it.
- The FSM and registers live in pipe_sum_accum.

Test Plan (N=5, ACC_W=8, COUNT=4 unless stated):
- Basic: v=10,20,30,40 on consecutive cycles → out_valid=1 the cycle after the 4th accept; out_acc=100; out_ovf=0; in_ready=0 during DONE.
- Gapped input: v=5, idle 3 cycles, 6, idle 1 cycle, 7, 8 → out_acc=26. Cycles with in_valid=0 leave cnt/acc unchanged.
- Overflow, ACC_W=7: v=63 ×4 → wrap build out_acc=124, out_ovf=1; with PIPE_SUM_ACCUM_SAT_EN out_acc=127, out_ovf=1.
- Backpressure: block completes with out_ready=0 for 3 cycles while in_valid=1 → out_acc held, in_ready=0, no input consumed. out_ready=1 → IDLE next cycle, and the held input is accepted on the following edge.
- Reset mid-block: accept 9 and 11, pulse rst_n low between clock edges → out_valid=0, out_acc=0. Then a fresh block 1,2,3,4 → out_acc=10.
- COUNT=1: v=33 → out_valid the next cycle with out_acc=33. Back-to-back inputs are accepted every other cycle.

Source files
------------

// File: rtl/pipe_accum_pkg.sv
// +----------------------------------------------------------------------+
// | Package   : pipe_accum_pkg                                            |
// | Purpose   : Shared state encoding and sizing helper for the block     |
// |             accumulator that follows the pipelined split adder.       |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_accum_pkg;

  // Binary-encoded block state: collecting operands, then holding the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

  // Counter width able to hold the values 0..COUNT inclusive.
  function automatic int cnt_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sum_accum_add.sv
// +----------------------------------------------------------------------+
// | Module    : accum_add                                                 |
// | Purpose   : Combinational ACC_W-bit add of the running total and one  |
// |             zero-extended adder result; reports the carry out.        |
// | Options   : PIPE_SUM_ACCUM_SAT_EN - clamp to all-ones on overflow     |
// |             instead of wrapping.                                      |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module accum_add #(
  parameter int N     = 5,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [N:0]       v,
  output logic [ACC_W-1:0] acc_next,
  output logic             ovf
);

  // One extra bit captures the carry out of bit ACC_W-1.
  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + (ACC_W+1)'(v);
  assign ovf = sum[ACC_W];

`ifdef PIPE_SUM_ACCUM_SAT_EN
  // Once clamped, any further nonzero operand overflows again, so the
  // total stays pinned at all-ones for the rest of the block.
  assign acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/pipe_sum_accum.sv
// +----------------------------------------------------------------------+
// | Module    : pipe_sum_accum                                            |
// | Purpose   : Accumulates COUNT consecutive {cout, sum} adder results   |
// |             into an ACC_W-bit total and presents it on a held         |
// |             valid/ready output with a sticky overflow flag.           |
// | Options   : PIPE_SUM_ACCUM_SAT_EN - saturating accumulation           |
// |             (handled inside accum_add).                               |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_sum_accum
  import pipe_accum_pkg::*;
#(
  parameter int N     = 5,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int             CNT_W    = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  accum_state_t     state;
  accum_state_t     state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [N:0]       v;
  logic [ACC_W-1:0] add_acc;
  logic             add_ovf;
  logic             in_fire;
  logic             out_fire;

  assign v        = {in_cout, in_sum};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_acc  = acc;
  assign out_ovf  = ovf;

  accum_add #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_add (
    .acc      (acc),
    .v        (v),
    .acc_next (add_acc),
    .ovf      (add_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; in_ready comes from state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_nxt = (COUNT == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire && (cnt == CNT_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_fire) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Running total, operand count and sticky overflow for the current block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            acc <= ACC_W'(v);
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc <= add_acc;
            ovf <= ovf | add_ovf;
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_fire) begin
            cnt <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
